// File: rtl/ihex_if.sv
// ihex_if: Wishbone pipelined master/slave bundle used by the Intel HEX loader
interface ihex_if #(
    parameter int WB_AW = 30,
    parameter int WB_DW = 32
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_AW-1:0]     addr;
    logic [WB_DW-1:0]     mosi_data;
    logic [WB_DW-1:0]     miso_data;
    logic [WB_DW/8-1:0]   sel;
    logic                 ack;
    logic                 stall;
    logic                 err;
    modport master(output cyc, stb, we, addr, mosi_data, sel, input ack, stall, err, miso_data);
    modport slave(input cyc, stb, we, addr, mosi_data, sel, output ack, stall, err, miso_data);
endinterface

// File: rtl/ihex_loader.sv
// ihex_loader: parses Intel HEX records from a UART byte stream into coalesced Wishbone word writes
module ihex_loader #(
    parameter int WB_DW      = 32,
    parameter int WB_AW      = 30,
    parameter int MAX_LEN    = 255,
    parameter int BIG_ENDIAN = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_stb,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_stb,
    input  logic        i_tx_busy,
    ihex_if.master      wb,
    output logic [31:0] o_start_addr,
    output logic        o_start_valid,
    output logic        o_busy
);
    localparam int LANES = WB_DW / 8;
    localparam int LB    = $clog2(LANES);
    localparam int BL    = MAX_LEN < 4 ? 4 : MAX_LEN;
    localparam int IW    = $clog2(BL);
    typedef enum logic [3:0] {IDLE, LEN, ADDR, TYPE, DATA, CKSUM, CHECK, WB_REQ, WB_WAIT, ACK} state_t;
    state_t state_q, state_d;
    logic [8:0]  cnt;
    logic [3:0]  hi, nib;
    logic [7:0]  len, typ, sum, idx, tx_char, bval;
    logic [15:0] aaaa;
    logic [31:0] base, ba, off;
    logic [7:0]  mem [BL];
    logic [LANES-1:0] sel_c;
    logic [WB_DW-1:0] data_c;
    logic [8:0]  nb;
    logic        is_hex, colon, parse, fend, last, unused;
    function automatic int pos(input int l);
        return BIG_ENDIAN != 0 ? LANES - 1 - l : l;
    endfunction
    assign is_hex = (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) || (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)
                  || (i_rx_data >= 8'h41 && i_rx_data <= 8'h46);
    assign nib    = i_rx_data <= 8'h39 ? i_rx_data[3:0] : i_rx_data[3:0] + 4'd9;
    assign colon  = i_rx_data == 8'h3A;
    assign bval   = {hi, nib};
    assign parse  = state_q inside {LEN, ADDR, TYPE, DATA, CKSUM};
    assign fend   = state_q == ADDR ? cnt == 9'd3 : state_q == DATA ? cnt == {len, 1'b0} - 9'd1 : cnt == 9'd1;
    // Current beat: every remaining byte that shares the word address of byte idx
    assign ba  = base + {16'h0, aaaa} + {24'h0, idx};
    assign off = ba & 32'(LANES - 1);
    always_comb begin
        sel_c  = '0;
        data_c = '0;
        nb     = '0;
        for (int l = 0; l < LANES; l++) begin
            if (pos(l) >= int'(off) && int'(idx) + pos(l) - int'(off) < int'(len)) begin
                sel_c[l]         = 1'b1;
                data_c[l*8 +: 8] = mem[IW'(int'(idx) + pos(l) - int'(off))];
                nb               = nb + 9'd1;
            end
        end
    end
    assign last         = ({1'b0, idx} + nb) >= {1'b0, len};
    assign wb.cyc       = !i_reset && (state_q == WB_REQ || state_q == WB_WAIT);
    assign wb.stb       = !i_reset && state_q == WB_REQ;
    assign wb.we        = 1'b1;
    assign wb.addr      = WB_AW'(ba >> LB);
    assign wb.sel       = wb.stb ? sel_c : '0;
    assign wb.mosi_data = data_c;
    assign unused       = ^wb.miso_data;
    assign o_tx_stb     = !i_reset && state_q == ACK && !i_tx_busy;
    assign o_busy       = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        tx_char = "M";
        case (state_q)
            IDLE: if (i_rx_stb && colon) state_d = LEN;
            LEN, ADDR, TYPE, DATA, CKSUM:
                if (i_rx_stb)
                    state_d = colon ? LEN : !is_hex ? ACK : !fend ? state_q : state_q == LEN ? ADDR
                            : state_q == ADDR ? TYPE : state_q == TYPE ? (len == 8'd0 ? CKSUM : DATA)
                            : state_q == DATA ? CKSUM : CHECK;
            CHECK: begin
                tx_char = sum != 8'd0 ? "E" : typ == 8'h00 ? (len > 8'(MAX_LEN) ? "M" : "K") : typ == 8'h01 ? "R"
                        : typ == 8'h02 || typ == 8'h04 ? (len == 8'd2 ? "S" : "M")
                        : typ == 8'h05 ? (len == 8'd4 ? "G" : "M") : "U";
                state_d = sum == 8'd0 && typ == 8'h00 && len != 8'd0 && len <= 8'(MAX_LEN) ? WB_REQ : ACK;
            end
            WB_REQ: begin
                tx_char = wb.err ? "W" : "K";
                state_d = wb.err ? ACK : wb.stall ? WB_REQ : !wb.ack ? WB_WAIT : last ? ACK : WB_REQ;
            end
            WB_WAIT: begin
                tx_char = wb.err ? "W" : "K";
                state_d = wb.err ? ACK : !wb.ack ? WB_WAIT : last ? ACK : WB_REQ;
            end
            ACK: if (!i_tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge i_clk) begin
        if (state_q == DATA && i_rx_stb && is_hex && cnt[0] && int'(cnt[8:1]) < BL) mem[IW'(cnt[8:1])] <= bval;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            base          <= '0;
            o_tx_data     <= '0;
            o_start_addr  <= '0;
            o_start_valid <= 1'b0;
            cnt           <= '0;
            sum           <= '0;
            idx           <= '0;
            hi            <= '0;
            len           <= '0;
            typ           <= '0;
            aaaa          <= '0;
        end else begin
            o_start_valid <= 1'b0;
            if (state_d == ACK && state_q != ACK) o_tx_data <= tx_char;
            if (i_rx_stb && (state_q == IDLE || parse) && colon) begin
                sum <= '0;
                cnt <= '0;
            end else if (i_rx_stb && parse && is_hex) begin
                hi  <= nib;
                cnt <= fend ? '0 : cnt + 9'd1;
                if (cnt[0]) begin
                    sum <= sum + bval;
                    if (state_q == LEN) len <= bval;
                    if (state_q == TYPE) typ <= bval;
                    if (state_q == ADDR) aaaa <= {aaaa[7:0], bval};
                end
            end
            if (state_q == CHECK && sum == 8'd0) begin
                idx <= '0;
                if (typ == 8'h01) base <= '0;
                if (typ == 8'h02 && len == 8'd2) base <= {12'h0, mem[0], mem[1], 4'h0};
                if (typ == 8'h04 && len == 8'd2) base <= {mem[0], mem[1], 16'h0};
                if (typ == 8'h05 && len == 8'd4) begin
                    o_start_addr  <= {mem[0], mem[1], mem[2], mem[3]};
                    o_start_valid <= 1'b1;
                end
            end
            if (((state_q == WB_REQ && !wb.stall) || state_q == WB_WAIT) && wb.ack) idx <= idx + nb[7:0];
        end
    end
endmodule

// File: tb/tb_ihex_loader.sv
// tb_ihex_loader: directed and randomized record streams against a byte-level reference model
module tb_ihex_loader;
    typedef logic [7:0] u8;
    logic        i_clk = 0, i_reset = 1, rx_stb = 0, tx_busy = 0;
    logic [7:0]  rx_data = 0, tx_data;
    logic        tx_stb, start_valid, busy;
    logic [31:0] start_addr;
    ihex_if #(.WB_AW(30), .WB_DW(32)) wb();
    ihex_loader #(.WB_DW(32), .WB_AW(30), .MAX_LEN(255), .BIG_ENDIAN(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(rx_data), .i_rx_stb(rx_stb),
        .o_tx_data(tx_data), .o_tx_stb(tx_stb), .i_tx_busy(tx_busy), .wb(wb),
        .o_start_addr(start_addr), .o_start_valid(start_valid), .o_busy(busy));
    always #5 i_clk = ~i_clk;
    int checks = 0, errors = 0;
    bit ack_comb = 0, err_mode = 0, no_ack = 0;
    int stall_req = 0, stl_cnt = 0;
    logic ack_q = 0, err_q = 0;
    bit acc_n = 0, stall_n = 0, cyc_n = 0, prev_stall = 0;
    logic [65:0] hold = '0;
    logic [29:0] got_a[$];
    logic [3:0]  got_s[$];
    logic [31:0] got_d[$];
    u8 tx_q[$];
    int start_pulses = 0, cyc_cycles = 0, stb_cycles = 0, unstable = 0;
    assign wb.stall     = stl_cnt < stall_req;
    assign wb.ack       = ack_q || (ack_comb && !err_mode && !no_ack && wb.cyc && wb.stb && !wb.stall);
    assign wb.err       = err_q;
    assign wb.miso_data = '0;
    // Slave bus observation happens mid-cycle; its registered responses update on the edge
    always @(negedge i_clk) begin
        acc_n   = wb.cyc && wb.stb && !wb.stall;
        stall_n = wb.cyc && wb.stb && wb.stall;
        cyc_n   = wb.cyc;
        if (wb.cyc) cyc_cycles++;
        if (wb.cyc && wb.stb) begin
            stb_cycles++;
            if (prev_stall && {wb.addr, wb.sel, wb.mosi_data} !== hold) unstable++;
            hold = {wb.addr, wb.sel, wb.mosi_data};
            prev_stall = wb.stall;
        end else prev_stall = 0;
        if (acc_n) begin
            got_a.push_back(wb.addr);
            got_s.push_back(wb.sel);
            got_d.push_back(wb.mosi_data);
        end
        if (tx_stb) tx_q.push_back(tx_data);
        if (start_valid) start_pulses++;
    end
    always @(posedge i_clk) begin
        ack_q   <= acc_n && !ack_comb && !err_mode && !no_ack;
        err_q   <= acc_n && err_mode;
        stl_cnt <= !cyc_n ? 0 : stall_n ? stl_cnt + 1 : stl_cnt;
    end
    logic [31:0] m_base = 0, m_start = 0;
    logic [29:0] exp_a[$];
    logic [3:0]  exp_s[$];
    logic [31:0] exp_d[$];
    task automatic model(input u8 b[$], input bit bad, output u8 st);
        logic [31:0] ba;
        int ll, n;
        ll = int'(b[0]);
        exp_a.delete(); exp_s.delete(); exp_d.delete();
        if (bad) st = "E";
        else if (b[3] == 8'h00) begin
            for (int i = 0; i < ll; i++) begin
                ba = m_base + {16'h0, b[1], b[2]} + 32'(i);
                if (exp_a.size() == 0 || exp_a[exp_a.size()-1] != ba[31:2]) begin
                    exp_a.push_back(ba[31:2]); exp_s.push_back(4'h0); exp_d.push_back(32'h0);
                end
                n = exp_a.size() - 1;
                exp_s[n] = exp_s[n] | 4'(1 << (3 - int'(ba[1:0])));
                exp_d[n] = exp_d[n] | (32'(b[4+i]) << (8 * (3 - int'(ba[1:0]))));
            end
            st = "K";
        end else if (b[3] == 8'h01) begin m_base = 0; st = "R"; end
        else if (b[3] == 8'h02) begin
            st = ll == 2 ? "S" : "M";
            if (ll == 2) m_base = {12'h0, b[4], b[5], 4'h0};
        end else if (b[3] == 8'h04) begin
            st = ll == 2 ? "S" : "M";
            if (ll == 2) m_base = {b[4], b[5], 16'h0};
        end else if (b[3] == 8'h05) begin
            st = ll == 4 ? "G" : "M";
            if (ll == 4) m_start = {b[4], b[5], b[6], b[7]};
        end else st = "U";
    endtask
    function automatic string rec_str(input u8 b[$], input bit bad, input bit lc);
        u8 s = 0;
        string r = ":";
        foreach (b[i]) begin
            s += b[i];
            r = {r, lc ? $sformatf("%02x", b[i]) : $sformatf("%02X", b[i])};
        end
        s = 8'h00 - s + (bad ? 8'h01 : 8'h00);
        return {r, lc ? $sformatf("%02x", s) : $sformatf("%02X", s)};
    endfunction
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data = s[i];
            rx_stb = 1;
            @(negedge i_clk);
            rx_stb = 0;
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
    endtask
    task automatic wait_tx(input int n0, output u8 st);
        for (int i = 0; i < 3000 && tx_q.size() <= n0; i++) @(negedge i_clk);
        st = tx_q.size() > n0 ? tx_q[n0] : 8'h00;
        repeat (4) @(negedge i_clk);
    endtask
    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++;
        if ({wb.cyc, wb.stb, wb.sel, tx_stb, start_valid} !== 8'h0) begin
            errors++; $display("FAIL reset_in_reset: got %b expected 0", {wb.cyc, wb.stb, wb.sel, tx_stb, start_valid});
        end
        i_reset = 0;
        @(negedge i_clk);
        checks++;
        if ({tx_data, start_addr, busy, wb.cyc, wb.stb, wb.sel} !== 47'h0) begin
            errors++; $display("FAIL reset_state: tx=%h start=%h busy=%b cyc=%b sel=%h", tx_data, start_addr, busy, wb.cyc, wb.sel);
        end
    endtask
    task automatic test_plan_data();
        int n0, a0, c0;
        u8 st;
        ack_comb = 0;
        n0 = tx_q.size(); a0 = got_a.size();
        send_str(":040010001122334442");
        wait_tx(n0, st);
        checks++;
        if (st !== "K" || got_a.size() - a0 != 1) begin errors++; $display("FAIL aligned_rec: status %h beats %0d expected K/1", st, got_a.size() - a0); end
        checks++;
        if ({got_a[a0], got_s[a0], got_d[a0]} !== {30'h4, 4'hF, 32'h11223344}) begin
            errors++; $display("FAIL aligned_beat: got %h/%h/%h expected 4/f/11223344", got_a[a0], got_s[a0], got_d[a0]);
        end
        ack_comb = 1;
        n0 = tx_q.size(); a0 = got_a.size();
        send_str(":03000100AABBCCCB");
        wait_tx(n0, st);
        checks++;
        if (st !== "K" || got_a.size() - a0 != 1) begin errors++; $display("FAIL unaligned_rec: status %h beats %0d expected K/1", st, got_a.size() - a0); end
        checks++;
        if ({got_a[a0], got_s[a0], got_d[a0]} !== {30'h0, 4'h7, 32'h00AABBCC}) begin
            errors++; $display("FAIL unaligned_beat: got %h/%h/%h expected 0/7/00aabbcc", got_a[a0], got_s[a0], got_d[a0]);
        end
        n0 = tx_q.size(); c0 = cyc_cycles;
        send_str(":03000100AABBCCCC");
        wait_tx(n0, st);
        checks++;
        if (st !== "E" || cyc_cycles != c0) begin errors++; $display("FAIL bad_cksum: status %h cyc cycles %0d expected E/0", st, cyc_cycles - c0); end
    endtask
    task automatic test_base();
        int n0, a0;
        u8 st;
        n0 = tx_q.size();
        send_str(":020000040001F9");
        wait_tx(n0, st);
        checks++;
        if (st !== "S") begin errors++; $display("FAIL ela_status: got %h expected S", st); end
        n0 = tx_q.size(); a0 = got_a.size();
        send_str(":0100000055AA");
        wait_tx(n0, st);
        checks++;
        if (st !== "K" || got_a.size() - a0 != 1 || {got_a[a0], got_s[a0], got_d[a0]} !== {30'h4000, 4'h8, 32'h55000000}) begin
            errors++; $display("FAIL ela_beat: status %h got %h/%h/%h expected K 4000/8/55000000", st, got_a[a0], got_s[a0], got_d[a0]);
        end
        n0 = tx_q.size();
        send_str(":00000001FF");
        wait_tx(n0, st);
        checks++;
        if (st !== "R") begin errors++; $display("FAIL eof_status: got %h expected R", st); end
        n0 = tx_q.size(); a0 = got_a.size();
        send_str(":0100000055AA");
        wait_tx(n0, st);
        checks++;
        if (st !== "K" || got_a.size() - a0 != 1 || got_a[a0] !== 30'h0) begin
            errors++; $display("FAIL base_cleared: status %h addr %h expected K/0", st, got_a[a0]);
        end
    endtask
    task automatic test_start();
        int n0, p0;
        u8 st;
        n0 = tx_q.size(); p0 = start_pulses;
        send_str(":0400000500001000E7");
        wait_tx(n0, st);
        checks++;
        if (st !== "G" || start_pulses - p0 != 1 || start_addr !== 32'h1000) begin
            errors++; $display("FAIL start_addr: status %h pulses %0d addr %h expected G/1/00001000", st, start_pulses - p0, start_addr);
        end
        n0 = tx_q.size();
        send_str(rec_str('{8'h03, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03}, 0, 0));
        wait_tx(n0, st);
        checks++;
        if (st !== "M") begin errors++; $display("FAIL bad_len: got %h expected M", st); end
        n0 = tx_q.size();
        send_str(rec_str('{8'h00, 8'h12, 8'h34, 8'h03}, 0, 0));
        wait_tx(n0, st);
        checks++;
        if (st !== "U") begin errors++; $display("FAIL unknown_type: got %h expected U", st); end
    endtask
    task automatic test_stall_err();
        int n0, a0, s0, u0;
        u8 st;
        stall_req = 3; ack_comb = 0;
        n0 = tx_q.size(); a0 = got_a.size(); s0 = stb_cycles; u0 = unstable;
        send_str(":040010001122334442");
        wait_tx(n0, st);
        stall_req = 0;
        checks++;
        if (st !== "K" || stb_cycles - s0 != 4 || unstable != u0 || got_a.size() - a0 != 1) begin
            errors++; $display("FAIL stall: status %h stb cycles %0d unstable %0d beats %0d expected K/4/0/1", st, stb_cycles - s0, unstable - u0, got_a.size() - a0);
        end
        err_mode = 1;
        n0 = tx_q.size(); a0 = got_a.size();
        send_str(rec_str('{8'h08, 8'h00, 8'h20, 8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8}, 0, 0));
        wait_tx(n0, st);
        err_mode = 0;
        checks++;
        if (st !== "W" || got_a.size() - a0 != 1) begin errors++; $display("FAIL bus_err: status %h beats %0d expected W/1", st, got_a.size() - a0); end
    endtask
    task automatic test_tx_busy();
        int n0;
        u8 st;
        tx_busy = 1;
        n0 = tx_q.size();
        send_str(":040010001122334442");
        repeat (40) @(negedge i_clk);
        checks++;
        if (tx_q.size() != n0 || busy !== 1'b1) begin errors++; $display("FAIL busy_hold: pulses %0d busy %b expected 0/1", tx_q.size() - n0, busy); end
        tx_busy = 0;
        wait_tx(n0, st);
        repeat (5) @(negedge i_clk);
        checks++;
        if (st !== "K" || tx_q.size() - n0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_release: status %h pulses %0d busy %b expected K/1/0", st, tx_q.size() - n0, busy);
        end
    endtask
    task automatic test_malformed();
        int n0;
        u8 st;
        n0 = tx_q.size();
        send_str(":04001G");
        wait_tx(n0, st);
        checks++;
        if (st !== "M" || busy !== 1'b0) begin errors++; $display("FAIL bad_char: status %h busy %b expected M/0", st, busy); end
        n0 = tx_q.size();
        send_str(":0400:00000001FF");
        wait_tx(n0, st);
        repeat (10) @(negedge i_clk);
        checks++;
        if (st !== "R" || tx_q.size() - n0 != 1) begin errors++; $display("FAIL restart: status %h count %0d expected R/1", st, tx_q.size() - n0); end
    endtask
    task automatic test_reset_mid();
        int n0, a0, i;
        u8 st;
        n0 = tx_q.size();
        send_str(":020000040001F9");
        wait_tx(n0, st);
        no_ack = 1;
        n0 = tx_q.size();
        send_str(":0100000055AA");
        for (i = 0; i < 200 && !wb.cyc; i++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        checks++;
        if (wb.cyc !== 1'b1 || wb.stb !== 1'b0) begin errors++; $display("FAIL wait_state: cyc %b stb %b expected 1/0", wb.cyc, wb.stb); end
        i_reset = 1;
        @(negedge i_clk);
        i_reset = 0;
        no_ack = 0;
        checks++;
        if (wb.cyc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid: cyc %b busy %b expected 0/0", wb.cyc, busy); end
        repeat (30) @(negedge i_clk);
        checks++;
        if (tx_q.size() != n0) begin errors++; $display("FAIL reset_no_status: got %0d status bytes expected 0", tx_q.size() - n0); end
        a0 = got_a.size();
        send_str(":0100000055AA");
        wait_tx(n0, st);
        checks++;
        if (st !== "K" || got_a.size() - a0 != 1 || got_a[a0] !== 30'h0) begin
            errors++; $display("FAIL reset_base: status %h addr %h expected K/0", st, got_a[a0]);
        end
    endtask
    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            u8 b[$];
            u8 st, est;
            int kind, ll, n0, a0, p0;
            bit bad;
            kind = $urandom_range(0, 9);
            bad = $urandom_range(0, 7) == 0;
            ack_comb = $urandom_range(0, 1);
            stall_req = $urandom_range(0, 2);
            ll = kind < 5 ? $urandom_range(1, 12) : kind == 5 || kind == 6 ? 2 : kind == 8 ? 4 : 0;
            b.push_back(8'(ll));
            b.push_back(8'($urandom)); b.push_back(8'($urandom));
            b.push_back(kind < 5 ? 8'h00 : kind == 5 ? 8'h04 : kind == 6 ? 8'h02 : kind == 7 ? 8'h01 : kind == 8 ? 8'h05 : 8'($urandom_range(6, 255)));
            for (int i = 0; i < ll; i++) b.push_back(8'($urandom));
            model(b, bad, est);
            n0 = tx_q.size(); a0 = got_a.size(); p0 = start_pulses;
            send_str(rec_str(b, bad, 1'($urandom_range(0, 1))));
            wait_tx(n0, st);
            checks++;
            if (st !== est || got_a.size() - a0 != exp_a.size()) begin
                errors++; $display("FAIL rand_rec%0d: status %h beats %0d expected %h/%0d", r, st, got_a.size() - a0, est, exp_a.size());
            end else
                for (int k = 0; k < exp_a.size(); k++) begin
                    checks++;
                    if ({got_a[a0+k], got_s[a0+k], got_d[a0+k]} !== {exp_a[k], exp_s[k], exp_d[k]}) begin
                        errors++; $display("FAIL rand_beat%0d_%0d: got %h/%h/%h expected %h/%h/%h", r, k,
                            got_a[a0+k], got_s[a0+k], got_d[a0+k], exp_a[k], exp_s[k], exp_d[k]);
                    end
                end
            checks++;
            if (start_pulses - p0 != int'(est == "G") || start_addr !== m_start) begin
                errors++; $display("FAIL rand_start%0d: pulses %0d addr %h expected %0d/%h", r, start_pulses - p0, start_addr, int'(est == "G"), m_start);
            end
        end
        stall_req = 0;
    endtask
    initial begin
        @(negedge i_clk);
        test_reset();
        test_plan_data();
        test_base();
        test_start();
        test_stall_err();
        test_tx_busy();
        test_malformed();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ihex_loader.md
Name: ihex_loader

Overview:
Parametrised Intel HEX record loader. Parses ASCII HEX records arriving on a UART byte stream and writes the data into any Wishbone slave. Returns one ASCII status byte per record on the UART TX side. Compared with the single-byte loader, this block:
- generalises bus width;
- coalesces consecutive bytes into word writes with a combined byte-select;
- supports record types 02 and 05;
- detects malformed characters;
- handshakes TX correctly.

Parameters:
WB_DW, 32, Wishbone data width in bits; must be 8, 16, 32 or 64. LANES = WB_DW/8.
WB_AW, 30, Wishbone word-address width; WB_AW <= 32 - log2(LANES).
MAX_LEN, 255, record-buffer depth in bytes (1..255). Data records with LL > MAX_LEN are rejected with 'M'.
BIG_ENDIAN, 1, 1: byte at offset 0 of a word goes to lane LANES-1 (MSB). 0: it goes to lane 0.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  received UART byte
i_rx_stb  in  1  i_rx_data valid, one cycle
o_tx_data  out  8  status character
o_tx_stb  out  1  one-cycle request to send o_tx_data
i_tx_busy  in  1  transmitter busy
wb  master  wishbone interface  cyc, stb, we (tied 1), addr[WB_AW], mosi_data[WB_DW], sel[LANES], ack, stall, err; miso_data unused
o_start_addr  out  32  address from the last type-05 record
o_start_valid  out  1  one-cycle pulse when o_start_addr updates
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; base 0; o_tx_stb 0; o_tx_data 0; cyc/stb 0; sel 0; o_start_addr 0; o_start_valid 0.
- Reset mid-transaction drops cyc/stb in the same cycle; no ack is awaited.
- Hex decoding: accept 0-9, a-f, A-F. Any other character inside a record aborts the record with 'M'.
- ':' received in any parse state restarts the record: sum is cleared, state goes to LEN.
- Parse states: IDLE -> LEN(2 nibbles) -> ADDR(4) -> TYPE(2) -> DATA(2*LL, skipped when LL=0) -> CKSUM(2) -> CHECK.
- All parse transitions occur only on i_rx_stb.
- Checksum: 8-bit sum of LL, both address bytes, type, all data bytes and the checksum byte must be 0x00. Otherwise send 'E' and perform no side effects.
- CHECK, by type:
  - 00 with LL=0: 'K'.
  - 00 with LL>0: go to WB_REQ.
  - 01: base <= 0, 'R'.
  - 02 (LL must be 2): base <= {12'h0, D0, D1, 4'h0}, 'S'.
  - 04 (LL must be 2): base <= {D0, D1, 16'h0}, 'S'.
  - 05 (LL must be 4): o_start_addr <= {D0..D3}, o_start_valid pulses, 'G'.
  - 02/04/05 with the wrong LL: 'M'.
  - Any other type: 'U'.
- Byte address for data byte i = base + AAAA + i, 32-bit, wrap modulo 2^32.
  - Word address = byte_addr >> log2(LANES), truncated to WB_AW.
  - Lane offset = byte_addr mod LANES.
- Coalescing: bytes with equal word address form one beat. sel = OR of their lane bits; unselected lanes of mosi_data are 0. A record starting unaligned produces a partial first beat and a partial last beat.
- Beat count = number of distinct word addresses touched. The beat for byte i+1 is assembled while beat i is in flight, or in the cycle after ack; no added idle cycles are required.
- WB_REQ: cyc=1, stb=1, addr/sel/data stable until the cycle with stall=0. If ack is sampled in that same cycle, advance; otherwise go to WB_WAIT.
- WB_WAIT: cyc=1, stb=0 until ack or err.
  - ack: next beat (WB_REQ), or 'K' after the last beat.
  - err (in either state): abort the remaining beats, 'W'.
  - ack and err together: err wins.
- ACK: o_tx_data is held. o_tx_stb pulses for one cycle in the first cycle with i_tx_busy=0, then state goes to IDLE.
- RX bytes arriving outside the parse states (WB_REQ, WB_WAIT, ACK, CHECK) are dropped. The host must wait for the status byte before sending the next record.
- Exactly one status byte per record that reaches CHECK or is aborted with 'M'.

Test Plan:
1. ":040010001122334442" (DW=32, BE) -> exactly one beat: addr=0x4, sel=4'b1111, data=0x11223344. Then 'K'.
2. ":03000100AABBCCCB" -> one beat: addr=0x0, sel=4'b0111, data=0x00AABBCC. Then 'K'. Repeat with the checksum changed to CC -> 'E', cyc never asserted.
3. ":020000040001F9" -> 'S'. Then ":0100000055AA" -> beat addr=0x4000, sel=4'b1000, data=0x55000000, 'K'. Then ":00000001FF" -> 'R'. Then repeat the data record -> addr=0x0.
4. ":0400000500001000E7" -> o_start_addr=0x00001000, one-cycle o_start_valid, 'G'. ":03000004..." with a correct checksum -> 'M'. Type 03 with a correct checksum -> 'U'.
5. Test 1 with stall=1 for 3 cycles -> stb held 4 cycles, signals stable. Slave answers err -> 'W', no further beats. Separately, i_tx_busy high 5 cycles at ACK -> o_tx_stb fires once, after busy falls.
6. ":04001G" -> 'M', back to IDLE. ":0400" then ":00000001FF" -> restart, single 'R'. i_reset asserted during WB_WAIT -> cyc=0 next cycle, base=0, no status byte sent.
